// File: rtl/mac_row_engine.sv
// Row of N_MACS saturating signed MAC lanes fed by a valid/ready beat stream.
// Activations are either broadcast to every lane or skewed down a systolic chain.
module mac_row_engine #(
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int KW     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [KW-1:0]           k_len,
  input  logic                    clear,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [W-1:0]            a_in,
  input  logic [N_MACS*W-1:0]     w_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_MACS*ACC_W-1:0] acc_out,
  output logic [N_MACS-1:0]       sat_out,
  output logic                    busy
);

  localparam int FW = (N_MACS > 1) ? $clog2(N_MACS) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, OUT} state_t;

  state_t          state, next;
  logic [KW-1:0]   cnt;
  logic [FW-1:0]   fcnt;
  logic            mode_r;
  logic            start_ok;
  logic            beat;
  logic            last_beat;

  assign start_ok  = (state == IDLE) && start && (k_len != '0);
  assign beat      = (state == STREAM) && a_valid;
  assign last_beat = beat && (cnt == KW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:   if (start_ok) next = STREAM;
      STREAM: if (last_beat) next = (mode_r && (N_MACS > 1)) ? FLUSH : OUT;
      FLUSH:  if (fcnt == FW'(1)) next = OUT;
      OUT:    if (out_ready) next = IDLE;
      default: next = IDLE;
    endcase
    if (clear) next = IDLE;
  end

  always_comb begin
    a_ready   = (state == STREAM);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  // Beat counter during STREAM, drain counter so the last lane sees the final beat.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt    <= '0;
      fcnt   <= '0;
      mode_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          cnt    <= k_len;
          mode_r <= mode;
        end
        STREAM: if (beat) begin
          cnt <= cnt - KW'(1);
          if (last_beat) fcnt <= FW'(N_MACS - 1);
        end
        FLUSH: fcnt <= fcnt - FW'(1);
        default: ;
      endcase
    end
  end

  for (genvar j = 0; j < N_MACS; j++) begin : g_lane
    logic                   lane_v;
    logic [W-1:0]           lane_a;
    logic [W-1:0]           lane_w;
    logic signed [2*W-1:0]  prod;
    logic [ACC_W:0]         sum;
    logic                   ovf;
    logic [ACC_W-1:0]       acc_r;
    logic                   sat_r;

    if (j == 0) begin : g_direct
      assign lane_v = beat;
      assign lane_a = a_in;
      assign lane_w = w_in[W-1:0];
    end else begin : g_skew
      logic         v_d [j];
      logic [W-1:0] a_d [j];
      logic [W-1:0] w_d [j];

      // Lane j sees each beat j cycles late; bubbles travel as invalid stages.
      always_ff @(posedge clk) begin
        if (rst || clear || start_ok) begin
          for (int k = 0; k < j; k++) begin
            v_d[k] <= 1'b0;
            a_d[k] <= '0;
            w_d[k] <= '0;
          end
        end else begin
          v_d[0] <= beat;
          a_d[0] <= a_in;
          w_d[0] <= w_in[j*W +: W];
          for (int k = 1; k < j; k++) begin
            v_d[k] <= v_d[k-1];
            a_d[k] <= a_d[k-1];
            w_d[k] <= w_d[k-1];
          end
        end
      end

      assign lane_v = mode_r ? v_d[j-1] : beat;
      assign lane_a = mode_r ? a_d[j-1] : a_in;
      assign lane_w = mode_r ? w_d[j-1] : w_in[j*W +: W];
    end

    assign prod = $signed(lane_a) * $signed(lane_w);
    assign sum  = {acc_r[ACC_W-1], acc_r} + {{(ACC_W+1-2*W){prod[2*W-1]}}, prod};
    assign ovf  = sum[ACC_W] ^ sum[ACC_W-1];

    always_ff @(posedge clk) begin
      if (rst || clear || start_ok) begin
        acc_r <= '0;
        sat_r <= 1'b0;
      end else if (lane_v) begin
        if (ovf) begin
          acc_r <= sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
          sat_r <= 1'b1;
        end else begin
          acc_r <= sum[ACC_W-1:0];
        end
      end
    end

    assign acc_out[j*ACC_W +: ACC_W] = acc_r;
    assign sat_out[j]                = sat_r;
  end

endmodule

// File: tb/tb_mac_row_engine.sv
// Scoreboard bench for mac_row_engine: a saturating reference model predicts each
// run's result when its beats are queued; results are popped on the output handshake.
module tb_mac_row_engine;

  localparam int W     = 8;
  localparam int ACC_W = 16;
  localparam int N     = 4;
  localparam int KW    = 8;

  logic                clk = 1'b0;
  logic                rst, start, mode, clear, a_valid, out_ready;
  logic [KW-1:0]       k_len;
  logic [W-1:0]        a_in;
  logic [N*W-1:0]      w_in;
  logic                a_ready, out_valid, busy;
  logic [N*ACC_W-1:0]  acc_out;
  logic [N-1:0]        sat_out;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [N*ACC_W-1:0] acc;
    logic [N-1:0]       sat;
  } result_t;

  result_t        exp_q[$];
  logic [W-1:0]   ba[$];
  logic [N*W-1:0] bw[$];

  mac_row_engine #(.W(W), .ACC_W(ACC_W), .N_MACS(N), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .k_len(k_len),
    .clear(clear), .a_valid(a_valid), .a_ready(a_ready), .a_in(a_in),
    .w_in(w_in), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .sat_out(sat_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] make_w(input int l0, input int l1, input int l2, input int l3);
    return {W'(l3), W'(l2), W'(l1), W'(l0)};
  endfunction

  function automatic result_t model();
    result_t      r;
    longint       acc [N];
    longint       p, s;
    logic [W-1:0] wj;
    longint       mx, mn;
    mx = (64'sd1 <<< (ACC_W-1)) - 1;
    mn = -mx - 1;
    r  = '0;
    for (int j = 0; j < N; j++) acc[j] = 0;
    for (int i = 0; i < ba.size(); i++) begin
      for (int j = 0; j < N; j++) begin
        wj = bw[i][j*W +: W];
        p  = longint'($signed(ba[i])) * longint'($signed(wj));
        s  = acc[j] + p;
        if (s > mx) begin s = mx; r.sat[j] = 1'b1; end
        if (s < mn) begin s = mn; r.sat[j] = 1'b1; end
        acc[j] = s;
      end
    end
    for (int j = 0; j < N; j++) r.acc[j*ACC_W +: ACC_W] = acc[j][ACC_W-1:0];
    return r;
  endfunction

  task automatic do_run(input logic m, input bit bubbles, output bit start_ok,
                        output int lat, output int flush);
    start = 1'b1; mode = m; k_len = KW'(ba.size());
    tick;
    start = 1'b0;
    start_ok = (busy === 1'b1) && (a_ready === 1'b1);
    for (int i = 0; i < ba.size(); i++) begin
      a_valid = 1'b1; a_in = ba[i]; w_in = bw[i];
      tick;
      if (bubbles && i < ba.size() - 1) begin
        a_valid = 1'b0;
        tick;
      end
    end
    a_valid = 1'b0;
    lat = 1; flush = 0;
    while (out_valid !== 1'b1) begin
      if (a_ready === 1'b0 && busy === 1'b1) flush++;
      if (lat >= 20) begin lat = -1; break; end
      tick;
      lat++;
    end
  endtask

  task automatic take_result(output logic [N*ACC_W-1:0] o_acc, output logic [N-1:0] o_sat);
    o_acc = acc_out; o_sat = sat_out;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    checks++;
    if ({busy, a_ready, out_valid} !== 3'b000) $display("[TB] FAIL reset_ctrl: got %b expected 000", {busy, a_ready, out_valid});
    else passed++;
    checks++;
    if (acc_out !== '0) $display("[TB] FAIL reset_acc: got %h expected 0", acc_out);
    else passed++;
    checks++;
    if (sat_out !== '0) $display("[TB] FAIL reset_sat: got %b expected 0", sat_out);
    else passed++;
  endtask

  task automatic test_broadcast;
    bit ok; int lat, fl; result_t er; logic [N*ACC_W-1:0] oa; logic [N-1:0] os;
    ba = {}; bw = {};
    for (int i = 1; i <= 3; i++) begin ba.push_back(W'(i)); bw.push_back(make_w(1, 2, 3, 4)); end
    exp_q.push_back(model());
    do_run(1'b0, 1'b0, ok, lat, fl);
    checks++;
    if (!ok) $display("[TB] FAIL bcast_start: busy/a_ready not high one cycle after start");
    else passed++;
    checks++;
    if (lat !== 1) $display("[TB] FAIL bcast_latency: got %0d expected 1", lat);
    else passed++;
    take_result(oa, os);
    er = exp_q.pop_front();
    checks++;
    if (oa !== er.acc || oa !== {16'd24, 16'd18, 16'd12, 16'd6}) $display("[TB] FAIL bcast_acc: got %h expected %h", oa, er.acc);
    else passed++;
    checks++;
    if (os !== er.sat) $display("[TB] FAIL bcast_sat: got %b expected %b", os, er.sat);
    else passed++;
    checks++;
    if ({out_valid, busy} !== 2'b00) $display("[TB] FAIL bcast_release: got %b expected 00", {out_valid, busy});
    else passed++;
  endtask

  task automatic test_systolic;
    bit ok; int lat, fl; result_t er; logic [N*ACC_W-1:0] oa; logic [N-1:0] os;
    exp_q.push_back(model());
    do_run(1'b1, 1'b0, ok, lat, fl);
    checks++;
    if (lat !== N) $display("[TB] FAIL sys_latency: got %0d expected %0d", lat, N);
    else passed++;
    checks++;
    if (fl !== N - 1) $display("[TB] FAIL sys_flush: got %0d expected %0d", fl, N - 1);
    else passed++;
    take_result(oa, os);
    er = exp_q.pop_front();
    checks++;
    if (oa !== er.acc) $display("[TB] FAIL sys_acc: got %h expected %h", oa, er.acc);
    else passed++;
    checks++;
    if (os !== er.sat) $display("[TB] FAIL sys_sat: got %b expected %b", os, er.sat);
    else passed++;
  endtask

  task automatic test_saturation;
    bit ok; int lat, fl; result_t er; logic [N*ACC_W-1:0] oa; logic [N-1:0] os;
    ba = {}; bw = {};
    for (int i = 0; i < 3; i++) begin ba.push_back(W'(127)); bw.push_back(make_w(127, 127, -128, -128)); end
    for (int m = 0; m < 2; m++) begin
      exp_q.push_back(model());
      do_run(m[0], 1'b0, ok, lat, fl);
      take_result(oa, os);
      er = exp_q.pop_front();
      checks++;
      if (oa !== er.acc || oa !== {16'h8000, 16'h8000, 16'h7fff, 16'h7fff}) $display("[TB] FAIL sat_acc_m%0d: got %h expected %h", m, oa, er.acc);
      else passed++;
      checks++;
      if (os !== 4'b1111) $display("[TB] FAIL sat_flags_m%0d: got %b expected 1111", m, os);
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    bit ok; int lat, fl; result_t er; logic [N*ACC_W-1:0] oa; logic [N-1:0] os;
    int stable = 0;
    ba = {}; bw = {};
    ba.push_back(W'(5));  bw.push_back(make_w(3, -7, 100, -1));
    ba.push_back(W'(-3)); bw.push_back(make_w(-9, 4, 50, 2));
    ba.push_back(W'(7));  bw.push_back(make_w(11, -2, -60, 8));
    ba.push_back(W'(2));  bw.push_back(make_w(-5, 6, 90, -4));
    exp_q.push_back(model());
    do_run(1'b1, 1'b1, ok, lat, fl);
    checks++;
    if (lat !== N) $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, N);
    else passed++;
    er = exp_q[0];
    for (int c = 0; c < 5; c++) begin
      if (out_valid === 1'b1 && acc_out === er.acc && sat_out === er.sat) stable++;
      start = (c == 2); k_len = KW'(2);
      tick;
    end
    start = 1'b0;
    checks++;
    if (stable !== 5) $display("[TB] FAIL bp_stable: got %0d stable cycles expected 5", stable);
    else passed++;
    checks++;
    if ({out_valid, busy} !== 2'b11) $display("[TB] FAIL bp_start_in_out: got %b expected 11", {out_valid, busy});
    else passed++;
    oa = acc_out; os = sat_out;
    out_ready = 1'b1; start = 1'b1;
    tick;
    out_ready = 1'b0; start = 1'b0;
    er = exp_q.pop_front();
    checks++;
    if (oa !== er.acc || os !== er.sat) $display("[TB] FAIL bp_result: got %h/%b expected %h/%b", oa, os, er.acc, er.sat);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL bp_handshake_start: got busy %b expected 0", busy);
    else passed++;
  endtask

  task automatic test_abort;
    int idle_cycles = 0;
    start = 1'b1; mode = 1'b0; k_len = KW'(5);
    tick;
    start = 1'b0;
    a_valid = 1'b1; a_in = W'(-128); w_in = make_w(-128, -128, -128, -128);
    tick; tick;
    a_valid = 1'b0;
    checks++;
    if (sat_out !== 4'b1111 || acc_out !== {4{16'h7fff}}) $display("[TB] FAIL abort_pre: got %h/%b expected 7fff x4/1111", acc_out, sat_out);
    else passed++;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    checks++;
    if ({busy, out_valid, a_ready} !== 3'b000 || acc_out !== '0 || sat_out !== '0)
      $display("[TB] FAIL abort_clear: got ctrl %b acc %h sat %b expected all 0", {busy, out_valid, a_ready}, acc_out, sat_out);
    else passed++;

    start = 1'b1; mode = 1'b1; k_len = KW'(2);
    tick;
    start = 1'b0;
    a_valid = 1'b1; a_in = W'(3); w_in = make_w(1, 2, 3, 4);
    tick;
    a_in = W'(4);
    tick;
    a_valid = 1'b0;
    checks++;
    if ({busy, a_ready} !== 2'b10 || acc_out[ACC_W-1:0] !== 16'd7) $display("[TB] FAIL abort_pre_flush: got ctrl %b lane0 %0d expected 10/7", {busy, a_ready}, acc_out[ACC_W-1:0]);
    else passed++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({busy, out_valid, a_ready} !== 3'b000 || acc_out !== '0 || sat_out !== '0)
      $display("[TB] FAIL abort_rst: got ctrl %b acc %h sat %b expected all 0", {busy, out_valid, a_ready}, acc_out, sat_out);
    else passed++;

    start = 1'b1; k_len = '0;
    tick;
    start = 1'b0;
    if (busy === 1'b0) idle_cycles++;
    tick;
    if (busy === 1'b0) idle_cycles++;
    checks++;
    if (idle_cycles !== 2) $display("[TB] FAIL abort_klen0: got %0d idle cycles expected 2", idle_cycles);
    else passed++;
  endtask

  task automatic test_back_to_back;
    bit ok; int lat, fl; result_t er; logic [N*ACC_W-1:0] oa; logic [N-1:0] os;
    ba = {}; bw = {};
    for (int i = 0; i < 3; i++) begin ba.push_back(W'(127)); bw.push_back(make_w(127, 127, 127, 127)); end
    exp_q.push_back(model());
    do_run(1'b0, 1'b0, ok, lat, fl);
    take_result(oa, os);
    er = exp_q.pop_front();
    checks++;
    if (oa !== er.acc || os !== er.sat) $display("[TB] FAIL b2b_first: got %h/%b expected %h/%b", oa, os, er.acc, er.sat);
    else passed++;
    checks++;
    if ({out_valid, busy} !== 2'b00) $display("[TB] FAIL b2b_release: got %b expected 00", {out_valid, busy});
    else passed++;
    ba = {}; bw = {};
    ba.push_back(W'(2));  bw.push_back(make_w(10, -20, 30, -40));
    ba.push_back(W'(-1)); bw.push_back(make_w(10, -20, 30, -40));
    exp_q.push_back(model());
    do_run(1'b1, 1'b0, ok, lat, fl);
    checks++;
    if (!ok) $display("[TB] FAIL b2b_start: second start not accepted right after handshake");
    else passed++;
    take_result(oa, os);
    er = exp_q.pop_front();
    checks++;
    if (oa !== er.acc || oa !== {16'hffd8, 16'd30, 16'hffec, 16'd10}) $display("[TB] FAIL b2b_acc: got %h expected %h", oa, er.acc);
    else passed++;
    checks++;
    if (os !== 4'b0000) $display("[TB] FAIL b2b_sat: got %b expected 0000", os);
    else passed++;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; clear = 1'b0; a_valid = 1'b0;
    out_ready = 1'b0; k_len = '0; a_in = '0; w_in = '0;
    #1;
    test_reset;
    test_broadcast;
    test_systolic;
    test_saturation;
    test_backpressure;
    test_abort;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
